// File: rtl/pwm_generator.sv
// Fixed-period PWM transmitter with a double-buffered duty register.
// New duty values are taken through a valid/ready handshake and applied only at a period boundary.
module pwm_generator #(
  parameter int PERIOD_CYCLES = 2000,
  parameter int DEFAULT_DUTY  = 1500,
  localparam int DW           = $clog2(PERIOD_CYCLES + 1)
) (
  input  logic          clock_i,
  input  logic          reset_i,
  input  logic          enable_i,
  input  logic [DW-1:0] duty_i,
  input  logic          duty_valid_i,
  output logic          duty_ready_o,
  output logic          pwm_o,
  output logic          period_start_o
);

  localparam logic [DW-1:0] PERIOD_DW  = DW'(PERIOD_CYCLES);
  localparam logic [DW-1:0] LAST_CNT   = DW'(PERIOD_CYCLES - 1);
  localparam logic [DW-1:0] DEFAULT_DW =
    DW'((DEFAULT_DUTY > PERIOD_CYCLES) ? PERIOD_CYCLES : DEFAULT_DUTY);

  logic [DW-1:0] cnt;
  logic [DW-1:0] cnt_inc;
  logic [DW-1:0] active_duty;
  logic [DW-1:0] pending;
  logic [DW-1:0] duty_clamped;
  logic [DW-1:0] next_duty;
  logic          pending_full;
  logic          running;
  logic          boundary;
  logic          accept;

  assign duty_ready_o = !pending_full;
  assign accept       = duty_valid_i && !pending_full;
  assign duty_clamped = (duty_i > PERIOD_DW) ? PERIOD_DW : duty_i;
  assign boundary     = !running || (cnt == LAST_CNT);
  assign next_duty    = pending_full ? pending : active_duty;
  assign cnt_inc      = cnt + DW'(1);

  // Accepts and boundary loads never collide: one needs pending empty, the other pending full.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      cnt            <= '0;
      running        <= 1'b0;
      active_duty    <= DEFAULT_DW;
      pending        <= '0;
      pending_full   <= 1'b0;
      pwm_o          <= 1'b0;
      period_start_o <= 1'b0;
    end else begin
      if (accept) begin
        pending      <= duty_clamped;
        pending_full <= 1'b1;
      end
      if (enable_i) begin
        if (boundary) begin
          cnt            <= '0;
          running        <= 1'b1;
          period_start_o <= 1'b1;
          pwm_o          <= (next_duty != '0);
          if (pending_full) begin
            active_duty  <= pending;
            pending_full <= 1'b0;
          end
        end else begin
          cnt            <= cnt_inc;
          period_start_o <= 1'b0;
          pwm_o          <= (cnt_inc < active_duty);
        end
      end else begin
        cnt            <= '0;
        running        <= 1'b0;
        pwm_o          <= 1'b0;
        period_start_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pwm_generator.sv
// Directed self-checking bench for pwm_generator with a 10-cycle period and default duty 4.
module tb_pwm_generator;

  localparam int PERIOD = 10;
  localparam int DW     = 4;

  logic          clock_i = 1'b0;
  logic          reset_i;
  logic          enable_i;
  logic [DW-1:0] duty_i;
  logic          duty_valid_i;
  logic          duty_ready_o;
  logic          pwm_o;
  logic          period_start_o;

  int checks = 0;
  int errors = 0;

  pwm_generator #(.PERIOD_CYCLES(PERIOD), .DEFAULT_DUTY(4)) dut (
    .clock_i        (clock_i),
    .reset_i        (reset_i),
    .enable_i       (enable_i),
    .duty_i         (duty_i),
    .duty_valid_i   (duty_valid_i),
    .duty_ready_o   (duty_ready_o),
    .pwm_o          (pwm_o),
    .period_start_o (period_start_o)
  );

  always #5 clock_i = ~clock_i;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic valid, input int duty, input logic enable);
    duty_valid_i = valid;
    duty_i       = DW'(duty);
    enable_i     = enable;
  endtask

  // Samples one cycle on the falling edge; position i of a period with 'high' high cycles.
  task automatic checkCycle(input string tag, input int i, input int high);
    @(negedge clock_i);
    checkOutput($sformatf("%s_ps%0d", tag, i), int'(period_start_o), int'(i == 0));
    checkOutput($sformatf("%s_pwm%0d", tag, i), int'(pwm_o), int'(i < high));
  endtask

  task automatic runPeriod(input string tag, input int high);
    for (int i = 0; i < PERIOD; i++) checkCycle(tag, i, high);
  endtask

  initial begin
    reset_i = 1'b1;
    applyStimulus(1'b0, 0, 1'b0);
    repeat (2) @(negedge clock_i);
    checkOutput("rst_pwm", int'(pwm_o), 0);
    checkOutput("rst_ps", int'(period_start_o), 0);
    checkOutput("rst_ready", int'(duty_ready_o), 1);
    reset_i = 1'b0;
    @(negedge clock_i);
    checkOutput("idle_pwm", int'(pwm_o), 0);
    checkOutput("idle_ready", int'(duty_ready_o), 1);

    applyStimulus(1'b0, 0, 1'b1);
    runPeriod("p1", 4);
    runPeriod("p2", 4);

    // Duty 7 written at count 3 waits for the next boundary
    for (int i = 0; i < PERIOD; i++) begin
      checkCycle("p3", i, 4);
      if (i == 3) applyStimulus(1'b1, 7, 1'b1);
      if (i == 4) begin
        checkOutput("p3_ready_low", int'(duty_ready_o), 0);
        applyStimulus(1'b0, 0, 1'b1);
      end
      if (i == 9) checkOutput("p3_ready_end", int'(duty_ready_o), 0);
    end

    // Fill pending with 7, then hold duty 2 valid while not ready
    for (int i = 0; i < PERIOD; i++) begin
      checkCycle("p4", i, 7);
      if (i == 0) checkOutput("p4_ready_back", int'(duty_ready_o), 1);
      if (i == 2) applyStimulus(1'b1, 7, 1'b1);
      if (i == 3) begin
        checkOutput("p4_ready_low", int'(duty_ready_o), 0);
        applyStimulus(1'b1, 2, 1'b1);
      end
      if (i == 9) checkOutput("p4_ready_end", int'(duty_ready_o), 0);
    end

    for (int i = 0; i < PERIOD; i++) begin
      checkCycle("p5", i, 7);
      if (i == 0) checkOutput("p5_ready_back", int'(duty_ready_o), 1);
      if (i == 1) begin
        checkOutput("p5_ready_taken", int'(duty_ready_o), 0);
        applyStimulus(1'b0, 0, 1'b1);
      end
    end

    // Duty 0 then duty 15 (clamped to full period)
    for (int i = 0; i < PERIOD; i++) begin
      checkCycle("p6", i, 2);
      if (i == 0) checkOutput("p6_ready_back", int'(duty_ready_o), 1);
      if (i == 5) applyStimulus(1'b1, 0, 1'b1);
      if (i == 6) applyStimulus(1'b0, 0, 1'b1);
    end
    runPeriod("p7", 0);
    for (int i = 0; i < PERIOD; i++) begin
      checkCycle("p8", i, 0);
      if (i == 5) applyStimulus(1'b1, 15, 1'b1);
      if (i == 6) applyStimulus(1'b0, 0, 1'b1);
    end
    runPeriod("p9", 10);
    for (int i = 0; i < PERIOD; i++) begin
      checkCycle("p10", i, 10);
      if (i == 5) applyStimulus(1'b1, 7, 1'b1);
      if (i == 6) applyStimulus(1'b0, 0, 1'b1);
    end

    // Disable at count 5, then re-enable
    for (int i = 0; i <= 5; i++) checkCycle("p11", i, 7);
    applyStimulus(1'b0, 0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock_i);
      checkOutput($sformatf("off_pwm%0d", i), int'(pwm_o), 0);
      checkOutput($sformatf("off_ps%0d", i), int'(period_start_o), 0);
    end
    applyStimulus(1'b0, 0, 1'b1);
    runPeriod("p12", 7);

    // Async reset mid high phase with a pending value of 9
    for (int i = 0; i <= 3; i++) begin
      checkCycle("p13", i, 7);
      if (i == 1) applyStimulus(1'b1, 9, 1'b1);
      if (i == 2) begin
        checkOutput("p13_ready_low", int'(duty_ready_o), 0);
        applyStimulus(1'b0, 0, 1'b1);
      end
    end
    #2 reset_i = 1'b1;
    #1;
    checkOutput("arst_pwm", int'(pwm_o), 0);
    checkOutput("arst_ready", int'(duty_ready_o), 1);
    checkOutput("arst_ps", int'(period_start_o), 0);
    @(negedge clock_i);
    checkOutput("arst_hold_pwm", int'(pwm_o), 0);
    reset_i = 1'b0;
    runPeriod("p14", 4);
    runPeriod("p15", 4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
